// File: rtl/aes_pkg.sv
// Shared AES decrypt-side definitions: FSM encoding, GF(2^8) helpers, row/column transforms.
// Latency: pure functions and constants, no state.
// Backpressure: not applicable.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } aes_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Byte k = row (k%4), column (k/4); byte 0 sits in bits [127:120].
  // Row r rotates right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3);
      o[119 - 32*c -: 8] = gf_mul_09(a0) ^ gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3);
      o[111 - 32*c -: 8] = gf_mul_0d(a0) ^ gf_mul_09(a1) ^ gf_mul_0e(a2) ^ gf_mul_0b(a3);
      o[103 - 32*c -: 8] = gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2) ^ gf_mul_0e(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// 16 parallel AES inverse S-box lookups across a full 128-bit block.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] din,
  output logic [AES_BLOCK_W-1:0] dout
);

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // One independent table lookup per byte lane
  for (genvar i = 0; i < 16; i++) begin : g_lane
    assign dout[8*i +: 8] = INV_SBOX[din[8*i +: 8]];
  end

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher, one round per clock; round keys fetched by index from an async-read store.
// Latency: result_valid pulses NR cycles after the accept edge; one block per NR+1 cycles.
// Backpressure: ready low while busy; start is ignored (not queued) unless ready is high.
module aes_inv_cipher_core
  import aes_pkg::*;
#(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [AES_BLOCK_W-1:0] block,
  output logic                   ready,
  output logic [KIDX_W-1:0]      round_key_idx,
  input  logic [AES_BLOCK_W-1:0] round_key,
  output logic [AES_BLOCK_W-1:0] result,
  output logic                   result_valid
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_core: NR must be 10, 12 or 14");
  end
  if ((1 << KIDX_W) <= NR) begin : g_bad_kidx
    $error("aes_inv_cipher_core: KIDX_W too narrow to index key NR");
  end

  localparam logic [KIDX_W-1:0] KEY_LAST = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] CTR_INIT = KIDX_W'(NR - 1);

  aes_state_e             fsm_q, fsm_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic [KIDX_W-1:0]      ctr_q, ctr_d;
  logic [AES_BLOCK_W-1:0] result_q, result_d;
  logic                   result_valid_q, result_valid_d;

  logic [AES_BLOCK_W-1:0] shifted, subbed, keyed, mixed;

  // ROUND and FINAL share the same shift/sub/add-key front end
  assign shifted = inv_shift_rows(data_q);
  aes_inv_sbox u_inv_sbox (
    .din  (shifted),
    .dout (subbed)
  );
  assign keyed = subbed ^ round_key;
  assign mixed = inv_mix_columns(keyed);

  // State register plus datapath flops; reset aborts any block in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q          <= ST_IDLE;
      data_q         <= '0;
      ctr_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      data_q         <= data_d;
      ctr_q          <= ctr_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Next-state: last middle round (counter at 1) hands over to FINAL
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (start) fsm_d = ST_ROUND;
      ST_ROUND: if (ctr_q == KIDX_W'(1)) fsm_d = ST_FINAL;
      ST_FINAL: fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  // Datapath updates: initial key whitening, middle rounds, final round to result
  always_comb begin
    data_d         = data_q;
    ctr_d          = ctr_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          data_d = block ^ round_key;
          ctr_d  = CTR_INIT;
        end
      end
      ST_ROUND: begin
        data_d = mixed;
        ctr_d  = ctr_q - KIDX_W'(1);
      end
      ST_FINAL: begin
        result_d       = keyed;
        result_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs decode from registered state only, so no start-to-index path
  always_comb begin
    ready         = 1'b0;
    round_key_idx = KEY_LAST;
    case (fsm_q)
      ST_IDLE: begin
        ready         = 1'b1;
        round_key_idx = KEY_LAST;
      end
      ST_ROUND: round_key_idx = ctr_q;
      ST_FINAL: round_key_idx = '0;
      default: ;
    endcase
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule
